// File: rtl/real_gain_pipe.sv
// real_gain_pipe
//   Streaming fixed-point gain stage. The real-valued GAIN parameter is turned
//   into a signed coefficient with FRAC_W fractional bits when the design is
//   elaborated. Each accepted sample is multiplied in stage 1, then rounded,
//   range-checked and registered in stage 2. Both stages use valid/ready
//   handshakes, so the block holds up to two samples and sustains one sample
//   per clock.
//
//   Optional feature macro: REAL_GAIN_SAT_EN
//     defined   : out-of-range results clamp to the signed output max/min
//     undefined : out-of-range results wrap (low OUT_W bits are kept)
//     ovf pulses in both builds, and the port list is the same in both.
//
// Ports
//   clk        in   rising-edge clock
//   reset_l    in   asynchronous active-low reset (release is synchronised upstream)
//   in_valid   in   input sample valid
//   in_ready   out  block accepts a sample this cycle
//   in_data    in   signed input sample, IN_W bits
//   out_valid  out  output sample valid
//   out_ready  in   downstream accepts the output this cycle
//   out_data   out  signed scaled sample, OUT_W bits
//   ovf        out  one-cycle pulse when an out-of-range sample is first presented
module real_gain_pipe #(
    parameter real GAIN   = 2.0,
    parameter int  IN_W   = 16,
    parameter int  OUT_W  = 16,
    parameter int  FRAC_W = 8,
    parameter int  COEF_W = 24
) (
    input  logic                    clk,
    input  logic                    reset_l,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    ovf
);

    localparam int PROD_W = IN_W + COEF_W;
    // One guard bit so that adding the rounding constant cannot overflow.
    localparam int SUM_W  = PROD_W + 1;

    // Round the scaled gain half away from zero, so that it is symmetric for negative gains.
    localparam real    ROUND_BIAS = (GAIN >= 0.0) ? 0.5 : -0.5;
    localparam longint COEF_L     = longint'($rtoi(GAIN * (2.0 ** FRAC_W) + ROUND_BIAS));
    localparam longint COEF_MAX   = (64'sd1 <<< (COEF_W - 1)) - 64'sd1;
    localparam longint COEF_MIN   = -(64'sd1 <<< (COEF_W - 1));
    localparam logic signed [COEF_W-1:0] COEF = COEF_W'(COEF_L);

    localparam logic signed [SUM_W-1:0] ROUND_ADD = SUM_W'(1) <<< (FRAC_W - 1);

    if (COEF_L > COEF_MAX || COEF_L < COEF_MIN) begin : g_coef_range_err
        $error("real_gain_pipe: coefficient %0d does not fit in %0d signed bits", COEF_L, COEF_W);
    end
    if (FRAC_W < 1) begin : g_frac_err
        $error("real_gain_pipe: FRAC_W must be at least 1");
    end
    if (SUM_W < OUT_W) begin : g_width_err
        $error("real_gain_pipe: product too narrow for OUT_W");
    end

    // Pipeline state
    logic                     s1_valid_reg;
    logic signed [PROD_W-1:0] prod_reg;
    logic                     s2_valid_reg;
    logic signed [OUT_W-1:0]  out_data_reg;
    logic                     ovf_reg;

    // Stage control: a stage may load when it is empty or when its content moves on.
    logic s2_adv;
    logic s1_adv;
    assign s2_adv = !s2_valid_reg || out_ready;
    assign s1_adv = !s1_valid_reg || s2_adv;

    // Stage 1 datapath: a full-width signed multiply
    logic signed [PROD_W-1:0] in_ext;
    logic signed [PROD_W-1:0] coef_ext;
    logic signed [PROD_W-1:0] prod_next;
    assign in_ext    = PROD_W'(in_data);
    assign coef_ext  = PROD_W'(COEF);
    assign prod_next = in_ext * coef_ext;

    // Stage 2 datapath: round half toward +inf, then check the range.
    // r_full keeps the full width after the arithmetic shift. The bits above the
    // output sign bit must all equal that sign bit for the value to fit.
    logic signed [SUM_W-1:0]   sum_rnd;
    logic signed [SUM_W-1:0]   r_full;
    logic [SUM_W-OUT_W:0]      r_hi;
    logic                      out_of_range;
    logic signed [OUT_W-1:0]   out_data_next;

    assign sum_rnd      = SUM_W'(prod_reg) + ROUND_ADD;
    assign r_full       = sum_rnd >>> FRAC_W;
    assign r_hi         = r_full[SUM_W-1:OUT_W-1];
    assign out_of_range = !((&r_hi) || !(|r_hi));

    always_comb begin
        out_data_next = r_full[OUT_W-1:0];
`ifdef REAL_GAIN_SAT_EN
        if (out_of_range) begin
            out_data_next = r_full[SUM_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                            : {1'b0, {(OUT_W-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            s1_valid_reg <= 1'b0;
            prod_reg     <= '0;
            s2_valid_reg <= 1'b0;
            out_data_reg <= '0;
            ovf_reg      <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    prod_reg <= prod_next;
                end
            end
            if (s2_adv) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_data_reg <= out_data_next;
                end
            end
            // Set only in the cycle after an out-of-range sample enters stage 2.
            // That is the first cycle in which the sample is presented, so the
            // flag stays a single pulse even while the output is stalled.
            ovf_reg <= s2_adv && s1_valid_reg && out_of_range;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_reg;
    assign out_data  = out_data_reg;
    assign ovf       = ovf_reg;

endmodule
